// File: rtl/preload_sequencer.sv
// Weight pre-load sequencer: streams a column-major N x N weight matrix,
// splits each weight into a reduced part for the systolic weight memory and
// a compensation part for up to CROWS outlier rows per column, pads unused
// compensation slots, and flags per-column outlier overflow.
module preload_sequencer #(
  parameter int N     = 8,
  parameter int WW    = 8,
  parameter int RW    = 5,
  parameter int CROWS = 3,
  localparam int CW   = WW - RW,
  localparam int NB   = $clog2(N),
  localparam int AW   = 2 * NB,
  localparam int CSW  = (CROWS > 1) ? $clog2(CROWS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          w_valid,
  output logic          w_ready,
  input  logic [WW-1:0] w_data,
  output logic          wm_we,
  output logic [AW-1:0] wm_addr,
  output logic [RW-1:0] wm_data,
  output logic          cm_we,
  output logic [NB-1:0] cm_col,
  output logic [CSW-1:0] cm_slot,
  output logic [NB-1:0] cm_row,
  output logic [CW-1:0] cm_weight,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  ovf
);

  // Slot counter must reach CROWS itself, so it is one state wider than cm_slot.
  localparam int SW = $clog2(CROWS + 1);
  localparam logic [SW-1:0] SLOT_FULL = SW'(CROWS);
  localparam logic [SW-1:0] SLOT_LAST = SW'(CROWS - 1);
  localparam logic [NB-1:0] IDX_LAST  = '1;

  typedef enum logic [1:0] {IDLE, LOAD, PAD, FIN} state_t;

  state_t        state, state_d;
  logic [NB-1:0] row, col;
  logic [SW-1:0] slot, slot_after;
  logic [CW-1:0] hi;
  logic [RW-1:0] lo;
  logic          accept, outlier, slot_avail;

  assign hi         = w_data[WW-1:RW];
  assign lo         = w_data[RW-1:0];
  assign outlier    = (hi != '0);
  assign slot_avail = (slot < SLOT_FULL);
  assign accept     = (state == LOAD) && w_valid;
  assign slot_after = (outlier && slot_avail) ? slot + SW'(1) : slot;

  assign w_ready = (state == LOAD);
  assign busy    = (state == LOAD) || (state == PAD);
  assign done    = (state == FIN);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  // Next-state decode; the PAD decision uses the slot count including the
  // outlier accepted on the column's last row.
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: if (start) state_d = LOAD;
      LOAD: begin
        if (accept && row == IDX_LAST) begin
          if (slot_after < SLOT_FULL) state_d = PAD;
          else if (col == IDX_LAST)   state_d = FIN;
        end
      end
      PAD:  if (slot == SLOT_LAST) state_d = (col == IDX_LAST) ? FIN : LOAD;
      FIN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counters, overflow flags and registered memory write strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row       <= '0;
      col       <= '0;
      slot      <= '0;
      ovf       <= '0;
      wm_we     <= 1'b0;
      wm_addr   <= '0;
      wm_data   <= '0;
      cm_we     <= 1'b0;
      cm_col    <= '0;
      cm_slot   <= '0;
      cm_row    <= '0;
      cm_weight <= '0;
    end else begin
      wm_we <= 1'b0;
      cm_we <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            row  <= '0;
            col  <= '0;
            slot <= '0;
            ovf  <= '0;
          end
        end
        LOAD: begin
          if (accept) begin
            wm_we   <= 1'b1;
            wm_addr <= {col, row};
            wm_data <= (outlier && !slot_avail) ? '1 : lo;
            if (outlier && slot_avail) begin
              cm_we     <= 1'b1;
              cm_col    <= col;
              cm_slot   <= slot[CSW-1:0];
              cm_row    <= row;
              cm_weight <= hi;
            end
            if (outlier && !slot_avail) ovf[col] <= 1'b1;
            row  <= row + NB'(1);
            slot <= slot_after;
            // Column already full of outliers: skip PAD and move straight on.
            if (row == IDX_LAST && slot_after == SLOT_FULL && col != IDX_LAST) begin
              col  <= col + NB'(1);
              slot <= '0;
            end
          end
        end
        PAD: begin
          cm_we     <= 1'b1;
          cm_col    <= col;
          cm_slot   <= slot[CSW-1:0];
          cm_row    <= '0;
          cm_weight <= '0;
          slot      <= slot + SW'(1);
          if (slot == SLOT_LAST && col != IDX_LAST) begin
            col  <= col + NB'(1);
            row  <= '0;
            slot <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_preload_sequencer.sv
// Self-checking bench for preload_sequencer: a matrix-level model predicts
// the ordered weight/compensation write streams, overflow flags and latency.
module tb_preload_sequencer;
  localparam int N = 8, WW = 8, RW = 5, CROWS = 3, NW = N * N;

  logic       clk = 1'b0, rst = 1'b0, start = 1'b0, w_valid = 1'b0;
  logic [7:0] w_data = '0;
  logic       w_ready, wm_we, cm_we, busy, done;
  logic [5:0] wm_addr;
  logic [4:0] wm_data;
  logic [2:0] cm_col, cm_row, cm_weight;
  logic [1:0] cm_slot;
  logic [7:0] ovf;

  preload_sequencer #(.N(N), .WW(WW), .RW(RW), .CROWS(CROWS)) dut (
    .clk(clk), .rst(rst), .start(start), .w_valid(w_valid), .w_ready(w_ready),
    .w_data(w_data), .wm_we(wm_we), .wm_addr(wm_addr), .wm_data(wm_data),
    .cm_we(cm_we), .cm_col(cm_col), .cm_slot(cm_slot), .cm_row(cm_row),
    .cm_weight(cm_weight), .busy(busy), .done(done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  logic [7:0]  W [NW];
  logic [10:0] exp_wm[$];   // {addr, reduced}
  logic [10:0] exp_cm[$];   // {col, slot, row, comp}
  logic [7:0]  exp_ovf;
  int          exp_pads;
  logic [4:0]  obs_wm [NW];
  logic [10:0] obs_cm[$];
  bit          acc_last = 1'b0, mon_en = 1'b0;
  int          done_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic check_zero(input string name);
    chk(name, {w_ready, wm_we, wm_addr, wm_data, cm_we, cm_col, cm_slot,
               cm_row, cm_weight, busy, done, ovf}, '0);
  endtask

  // Whole-matrix model: per column, first CROWS outliers get slots, the rest
  // saturate and flag overflow; unused slots are padded with zero entries.
  function automatic void build_model();
    exp_wm.delete(); exp_cm.delete(); exp_ovf = '0; exp_pads = 0;
    for (int c = 0; c < N; c++) begin
      int used = 0;
      for (int r = 0; r < N; r++) begin
        int w  = int'(W[c*N + r]);
        int hi = w / 32, lo = w % 32;
        logic [5:0] a = 6'(c*N + r);
        if (hi == 0) exp_wm.push_back({a, 5'(lo)});
        else if (used < CROWS) begin
          exp_wm.push_back({a, 5'(lo)});
          exp_cm.push_back({3'(c), 2'(used), 3'(r), 3'(hi)});
          used++;
        end else begin
          exp_wm.push_back({a, 5'd31});
          exp_ovf[c] = 1'b1;
        end
      end
      for (int s = used; s < CROWS; s++) begin
        exp_cm.push_back({3'(c), 2'(s), 3'd0, 3'd0});
        exp_pads++;
      end
    end
  endfunction

  // Compare process: every write strobe is checked against the model stream.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("wm_we_vs_accept", {63'd0, wm_we}, {63'd0, acc_last});
      if (wm_we) begin
        obs_wm[wm_addr] = wm_data;
        if (exp_wm.size() == 0) begin
          checks++; failures++;
          $display("FAIL wm_extra actual=%0h required=none", {wm_addr, wm_data});
        end else chk("wm_write", {wm_addr, wm_data}, exp_wm.pop_front());
      end
      if (cm_we) begin
        obs_cm.push_back({cm_col, cm_slot, cm_row, cm_weight});
        if (exp_cm.size() == 0) begin
          checks++; failures++;
          $display("FAIL cm_extra actual=%0h required=none", {cm_col, cm_slot, cm_row, cm_weight});
        end else chk("cm_write", {cm_col, cm_slot, cm_row, cm_weight}, exp_cm.pop_front());
      end
      if (done) done_cnt++;
    end
  end

  task automatic run_matrix(input bit rnd, input int abort_idx, input bit poke,
                            output int lat);
    int idx = 0, stalls = 0, budget = 0;
    bit acc, seen_done = 1'b0;
    build_model();
    done_cnt = 0; obs_cm.delete(); lat = 0;
    @(negedge clk); start = 1'b1; w_valid = 1'b0;
    @(posedge clk); lat = 1;
    forever begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin seen_done = 1'b1; break; end
      if (idx == abort_idx) begin
        #2 rst = 1'b0;
        #1 check_zero("abort_async_zero");
        acc_last = 1'b0;
        break;
      end
      if (budget++ > 2000) begin
        checks++; failures++;
        $display("FAIL timeout actual=idx%0d required=done", idx);
        break;
      end
      w_valid = (idx < NW) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
      w_data  = w_valid ? W[idx] : 8'($urandom);
      start   = poke && idx >= 10 && idx < 13;
      acc = w_valid && w_ready;
      if (w_ready && !w_valid) stalls++;
      @(posedge clk);
      acc_last = acc;
      lat++;
      if (acc) idx++;
    end
    w_valid = 1'b0;
    if (seen_done) begin
      start = poke;
      @(posedge clk); acc_last = 1'b0;
      @(negedge clk); start = 1'b0;
      chk("done_one_cycle", {63'd0, done}, 64'd0);
      chk("latency", lat, 1 + NW + exp_pads + stalls);
      chk("done_count", done_cnt, 1);
      chk("ovf", ovf, exp_ovf);
      chk("wm_left", exp_wm.size(), 0);
      chk("cm_left", exp_cm.size(), 0);
      repeat (2) begin
        @(negedge clk);
        chk("idle_after_done", {busy, w_ready, wm_we, cm_we}, 4'b0);
      end
    end
  endtask

  int lat;
  logic [10:0] c2[$], c5[$];

  initial begin
    #12 check_zero("reset_state");
    @(negedge clk); rst = 1'b1; mon_en = 1'b1;

    // Default matrix of 0x1F: no outliers, all slots padded.
    foreach (W[i]) W[i] = 8'h1F;
    run_matrix(1'b0, -1, 1'b0, lat);
    chk("lat_default_literal", lat, 89);
    chk("pads_default_literal", exp_pads, 24);
    chk("wm_data_addr63", obs_wm[63], 5'h1F);

    // Column 2 with three outliers, column 5 with five.
    foreach (W[i]) W[i] = 8'h01;
    W[17] = 8'hE3; W[20] = 8'hE3; W[22] = 8'hE3;
    for (int r = 0; r < 5; r++) W[40 + r] = 8'hFF;
    run_matrix(1'b0, -1, 1'b0, lat);
    chk("ovf_model_literal", exp_ovf, 8'h20);
    chk("ovf_literal", ovf, 8'h20);
    chk("wm17", obs_wm[17], 5'h03);
    chk("wm20", obs_wm[20], 5'h03);
    chk("wm22", obs_wm[22], 5'h03);
    chk("wm43_sat", obs_wm[43], 5'h1F);
    chk("wm16", obs_wm[16], 5'h01);
    foreach (obs_cm[i]) begin
      if (obs_cm[i][10:8] == 3'd2) c2.push_back(obs_cm[i]);
      if (obs_cm[i][10:8] == 3'd5) c5.push_back(obs_cm[i]);
    end
    chk("col2_cm", {c2.size() == 3 ? {c2[0], c2[1], c2[2]} : 33'h0},
        {3'd2, 2'd0, 3'd1, 3'd7, 3'd2, 2'd1, 3'd4, 3'd7, 3'd2, 2'd2, 3'd6, 3'd7});
    chk("col5_cm", {c5.size() == 3 ? {c5[0], c5[1], c5[2]} : 33'h0},
        {3'd5, 2'd0, 3'd0, 3'd7, 3'd5, 2'd1, 3'd1, 3'd7, 3'd5, 2'd2, 3'd2, 3'd7});
    repeat (3) @(negedge clk);
    chk("ovf_sticky", ovf, 8'h20);

    // Random weights with random valid gaps; one run pokes start mid-load and in done.
    for (int m = 0; m < 3; m++) begin
      foreach (W[i]) W[i] = ($urandom_range(0, 99) < 35) ? 8'($urandom_range(32, 255))
                                                          : 8'($urandom_range(0, 31));
      run_matrix(1'b1, -1, (m == 1), lat);
    end

    // Abort during column 3 with overflow already flagged in column 0.
    foreach (W[i]) W[i] = 8'h01;
    for (int r = 0; r < 5; r++) W[r] = 8'h80;
    run_matrix(1'b1, 26, 1'b0, lat);
    repeat (3) begin
      @(negedge clk);
      check_zero("held_reset_zero");
    end
    rst = 1'b1;

    // Clean matrix after the abort.
    foreach (W[i]) W[i] = 8'($urandom_range(0, 31));
    run_matrix(1'b1, -1, 1'b0, lat);
    chk("ovf_clean_after_abort", ovf, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end
endmodule

// File: doc/preload_sequencer.md
Name: preload_sequencer

Overview:
- Parametrised successor to the fixed 8x8 weight pre-load path of the low-cost TPU.
- Accepts a column-major N x N weight matrix through a valid/ready stream.
- Splits each weight into a reduced weight (low RW bits) for the systolic weight memory and a compensation weight (high bits) for the compensation memory.
- Tracks up to CROWS outlier rows per column, pads unused compensation slots, flags per-column overflow, and pulses done when the matrix is fully staged.

Parameters:
- N, 8: systolic array dimension (rows = columns = N), power of two, >= 2.
- WW, 8: input weight width, unsigned.
- RW, 5: reduced weight width; compensation width CW = WW-RW.
- CROWS, 3: compensation slots per column, >= 1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- start  in  1  begin a new matrix; sampled only in IDLE.
- w_valid  in  1  weight stream valid.
- w_ready  out  1  weight stream ready.
- w_data  in  WW  weight value.
- wm_we  out  1  weight-memory write enable.
- wm_addr  out  clog2(N*N)  weight-memory address = col*N+row.
- wm_data  out  RW  reduced weight.
- cm_we  out  1  compensation-memory write enable.
- cm_col  out  clog2(N)  column of the compensation entry.
- cm_slot  out  clog2(CROWS) (min 1)  slot index within the column.
- cm_row  out  clog2(N)  array row that the slot compensates.
- cm_weight  out  CW  compensation weight.
- busy  out  1  high in LOAD/PAD.
- done  out  1  one-cycle pulse at end of matrix.
- ovf  out  N  sticky per-column outlier overflow.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; row, col and slot counters = 0. All outputs = 0, including w_ready, wm_*, cm_*, busy, done and ovf.
- A reset asserted mid-matrix aborts with no further writes.
- States:
  - IDLE: w_ready=0. start=1 -> LOAD; clears counters and ovf.
  - LOAD: w_ready=1. An accept occurs when w_valid&w_ready. Row increments on each accept. At row=N-1 the accept moves to PAD if slot<CROWS; otherwise to the next column in LOAD, or to DONE if col=N-1.
  - PAD: w_ready=0. Issues one cm write per cycle (cm_weight=0, cm_row=0, cm_slot=slot) and increments slot until slot=CROWS. Then: col<N-1 -> col+1, row=0, slot=0, LOAD; else DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- All write outputs are registered: one-cycle latency from accept (or PAD cycle) to the wm_*/cm_* strobe. wm_we/cm_we are single-cycle strobes and are 0 otherwise.
- Split rule: hi = w_data[WW-1:RW], lo = w_data[RW-1:0]. Outlier iff hi != 0.
  - Non-outlier: wm_data=lo; no cm write.
  - Outlier with slot<CROWS: wm_data=lo, plus cm write {col, slot, row, hi}; slot+1.
  - Outlier with slot=CROWS: ovf[col]<=1; wm_data saturates to all ones (2^RW-1); no cm write.
- Every accept produces exactly one wm write; addresses cover 0..N*N-1 exactly once per matrix.
- Every column produces exactly CROWS cm writes, slots 0..CROWS-1 in ascending order.
- w_valid low in LOAD stalls the sequence with no writes; counters hold.
- start while busy or in DONE is ignored. w_data is ignored when w_ready=0.
- busy=1 in LOAD and PAD, 0 otherwise. ovf holds until the next accepted start.
- No backpressure from the memories; writes are never dropped.

Test Plan:
- Reset then start; stream 64 weights of 0x1F with w_valid held high (defaults) -> 64 wm writes, wm_addr 0..63, wm_data=0x1F. 24 cm writes, all weight 0 and row 0, slots 0,1,2 per column. done pulses at cycle 89 after start (64 accepts + 24 pads + DONE). ovf=0.
- Column 2: rows 1, 4 and 6 = 0xE3, others 0x01 -> cm writes (col2, slot0, row1, 7), (slot1, row4, 7), (slot2, row6, 7). No PAD cycles for col2. wm_data at 17/20/22 = 0x03.
- Column 5 with five outliers 0xFF at rows 0-4 -> first three produce cm slots 0-2. Rows 3 and 4 write wm_data=0x1F with no cm write. ovf=8'b0010_0000.
- Toggle w_valid randomly 50% -> write sequence and values identical to the stall-free run; no writes while w_valid=0.
- Assert rst low during column 3 -> all outputs 0 asynchronously. After release and a new start, a full clean matrix completes with ovf cleared.
- Pulse start during LOAD and during DONE -> no effect. The next start in IDLE begins a fresh matrix at wm_addr 0.
